cal_date_gen: RTL and testbench

- Calendar date generator that produces the date fields consumed by the calendar drawing stage: year, month, day in month, weekday of the 1st of the month, and days in the month.
- Advances one day per day_tick_i pulse from the time-of-day counter (midnight rollover).
- Accepts a direct date load from the settings logic; derives the month's first weekday with an iterative walk from a fixed epoch.
- Sits upstream of the calendar draw path; all outputs are registered.

---
 rtl/cal_date_gen.sv | 229 ++++++++++++++++++++++
 tb/tb_cal_date_gen.sv | 369 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cal_date_gen.sv
`default_nettype none
// ============================================================================
// Module      : cal_date_gen
// Description : Calendar date generator. It keeps the year, month and day in
//               month, and also the weekday of the 1st of the month and the
//               number of days in the month. The date advances one day on each
//               day_tick_i pulse. A direct load (set_en_i) clamps the fields to
//               legal values. It then finds the month's first weekday with an
//               iterative walk from the epoch BASE_YEAR-01-01.
// Ports       : clk_i, rst_i          clock, synchronous active-high reset
//               day_tick_i            advance one day
//               set_en_i, set_*_i     load a date (clamped)
//               year_o, month_o, day_in_month_o       current date
//               month_first_day_o     weekday of the 1st (0=Mon..6=Sun)
//               month_days_cnt_o      days in current month (28..31)
//               busy_o                recalculation after a load in progress
// Revision    : 1.0 - initial release
// ============================================================================
module cal_date_gen #(
    parameter int BASE_YEAR      = 2000,
    parameter int MAX_YEAR       = 2999,
    parameter int BASE_FIRST_DAY = 5,
    parameter int YEAR_W         = 12
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              day_tick_i,
    input  logic              set_en_i,
    input  logic [YEAR_W-1:0] set_year_i,
    input  logic [3:0]        set_month_i,
    input  logic [4:0]        set_day_i,
    output logic [YEAR_W-1:0] year_o,
    output logic [3:0]        month_o,
    output logic [4:0]        day_in_month_o,
    output logic [2:0]        month_first_day_o,
    output logic [4:0]        month_days_cnt_o,
    output logic              busy_o
);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        YEAR_WALK  = 2'd1,
        MONTH_WALK = 2'd2
    } state_t;

    localparam logic [YEAR_W-1:0] BASE_Y  = YEAR_W'(BASE_YEAR);
    localparam logic [YEAR_W-1:0] MAX_Y   = YEAR_W'(MAX_YEAR);
    localparam logic [2:0]        BASE_FD = 3'(BASE_FIRST_DAY);

    function automatic logic is_leap(input logic [YEAR_W-1:0] y);
        return ((y[1:0] == 2'b00) && ((y % YEAR_W'(100)) != '0)) ||
               ((y % YEAR_W'(400)) == '0);
    endfunction

    function automatic logic [4:0] month_len(input logic [3:0] m, input logic leap);
        case (m)
            4'd1:                      month_len = leap ? 5'd29 : 5'd28;
            4'd3, 4'd5, 4'd8, 4'd10:   month_len = 5'd30;
            default:                   month_len = 5'd31;
        endcase
    endfunction

    // Sums are formed at 6 bits (max 6+31) and then reduced to a weekday.
    function automatic logic [2:0] mod7(input logic [5:0] s);
        return 3'(s % 6'd7);
    endfunction

    state_t            state_q, state_d;
    logic [YEAR_W-1:0] year_q, year_d;
    logic [3:0]        month_q, month_d;
    logic [4:0]        day_q, day_d;
    logic [2:0]        fd_q, fd_d;
    logic [4:0]        cnt_q, cnt_d;
    logic              busy_q, busy_d;
    logic              pend_q, pend_d;
    logic [2:0]        acc_q, acc_d;
    logic [YEAR_W-1:0] wy_q, wy_d;
    logic [3:0]        wm_q, wm_d;
    logic [YEAR_W-1:0] ty_q, ty_d;
    logic [3:0]        tm_q, tm_d;
    logic [4:0]        td_q, td_d;

    // Clamped load fields. The day limit uses the clamped month and year.
    logic [YEAR_W-1:0] cl_year;
    logic [3:0]        cl_month;
    logic [4:0]        cl_len;
    logic [4:0]        cl_day;
    logic              tick;

    always_comb begin
        if (set_year_i < BASE_Y)     cl_year = BASE_Y;
        else if (set_year_i > MAX_Y) cl_year = MAX_Y;
        else                         cl_year = set_year_i;
        cl_month = (set_month_i > 4'd11) ? 4'd11 : set_month_i;
        cl_len   = month_len(cl_month, is_leap(cl_year));
        if (set_day_i == 5'd0)        cl_day = 5'd1;
        else if (set_day_i > cl_len)  cl_day = cl_len;
        else                          cl_day = set_day_i;
    end

    always_comb begin
        state_d = state_q;
        year_d  = year_q;
        month_d = month_q;
        day_d   = day_q;
        fd_d    = fd_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        pend_d  = pend_q;
        acc_d   = acc_q;
        wy_d    = wy_q;
        wm_d    = wm_q;
        ty_d    = ty_q;
        tm_d    = tm_q;
        td_d    = td_q;
        tick    = day_tick_i | pend_q;

        if (set_en_i) begin
            // A load always wins, restarts any walk and drops ticks.
            ty_d    = cl_year;
            tm_d    = cl_month;
            td_d    = cl_day;
            acc_d   = BASE_FD;
            wy_d    = BASE_Y;
            wm_d    = 4'd0;
            pend_d  = 1'b0;
            busy_d  = 1'b1;
            state_d = YEAR_WALK;
        end else begin
            case (state_q)
                IDLE: begin
                    pend_d = 1'b0;
                    if (tick) begin
                        if (day_q < cnt_q) begin
                            day_d = day_q + 5'd1;
                        end else begin
                            day_d = 5'd1;
                            fd_d  = mod7({3'b000, fd_q} + {1'b0, cnt_q});
                            if (month_q == 4'd11) begin
                                month_d = 4'd0;
                                if (year_q == MAX_Y) begin
                                    year_d = BASE_Y;
                                    fd_d   = BASE_FD;
                                end else begin
                                    year_d = year_q + YEAR_W'(1);
                                end
                            end else begin
                                month_d = month_q + 4'd1;
                            end
                            cnt_d = month_len(month_d, is_leap(year_d));
                        end
                    end
                end
                YEAR_WALK: begin
                    if (day_tick_i) pend_d = 1'b1;
                    if (wy_q == ty_q) begin
                        wm_d    = 4'd0;
                        state_d = MONTH_WALK;
                    end else begin
                        acc_d = mod7({3'b000, acc_q} + (is_leap(wy_q) ? 6'd2 : 6'd1));
                        wy_d  = wy_q + YEAR_W'(1);
                    end
                end
                MONTH_WALK: begin
                    if (day_tick_i) pend_d = 1'b1;
                    if (wm_q == tm_q) begin
                        year_d  = ty_q;
                        month_d = tm_q;
                        day_d   = td_q;
                        fd_d    = acc_q;
                        cnt_d   = month_len(tm_q, is_leap(ty_q));
                        busy_d  = 1'b0;
                        state_d = IDLE;
                    end else begin
                        acc_d = mod7({3'b000, acc_q} + {1'b0, month_len(wm_q, is_leap(ty_q))});
                        wm_d  = wm_q + 4'd1;
                    end
                end
                default: begin
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            year_q  <= BASE_Y;
            month_q <= 4'd0;
            day_q   <= 5'd1;
            fd_q    <= BASE_FD;
            cnt_q   <= 5'd31;
            busy_q  <= 1'b0;
            pend_q  <= 1'b0;
            acc_q   <= BASE_FD;
            wy_q    <= BASE_Y;
            wm_q    <= 4'd0;
            ty_q    <= BASE_Y;
            tm_q    <= 4'd0;
            td_q    <= 5'd1;
        end else begin
            state_q <= state_d;
            year_q  <= year_d;
            month_q <= month_d;
            day_q   <= day_d;
            fd_q    <= fd_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            pend_q  <= pend_d;
            acc_q   <= acc_d;
            wy_q    <= wy_d;
            wm_q    <= wm_d;
            ty_q    <= ty_d;
            tm_q    <= tm_d;
            td_q    <= td_d;
        end
    end

    assign year_o            = year_q;
    assign month_o           = month_q;
    assign day_in_month_o    = day_q;
    assign month_first_day_o = fd_q;
    assign month_days_cnt_o  = cnt_q;
    assign busy_o            = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_cal_date_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_cal_date_gen
// Description : Self-checking bench for cal_date_gen. The reference model
//               counts whole days since the epoch to find each month's first
//               weekday.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cal_date_gen;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        day_tick_i = 1'b0;
    logic        set_en_i = 1'b0;
    logic [11:0] set_year_i = '0;
    logic [3:0]  set_month_i = '0;
    logic [4:0]  set_day_i = '0;
    logic [11:0] year_o;
    logic [3:0]  month_o;
    logic [4:0]  day_in_month_o;
    logic [2:0]  month_first_day_o;
    logic [4:0]  month_days_cnt_o;
    logic        busy_o;

    cal_date_gen dut (
        .clk_i             (clk_i),
        .rst_i             (rst_i),
        .day_tick_i        (day_tick_i),
        .set_en_i          (set_en_i),
        .set_year_i        (set_year_i),
        .set_month_i       (set_month_i),
        .set_day_i         (set_day_i),
        .year_o            (year_o),
        .month_o           (month_o),
        .day_in_month_o    (day_in_month_o),
        .month_first_day_o (month_first_day_o),
        .month_days_cnt_o  (month_days_cnt_o),
        .busy_o            (busy_o)
    );

    always #5 clk_i = ~clk_i;

    int errors = 0;
    int checks = 0;
    int my = 2000, mm = 0, md = 1;   // model date

    // ---------------- reference model ----------------
    function automatic bit m_leap(int y);
        return ((y % 4 == 0) && (y % 100 != 0)) || (y % 400 == 0);
    endfunction

    function automatic int m_len(int m, int y);
        int t[12] = '{31, 28, 31, 30, 31, 30, 31, 31, 30, 31, 30, 31};
        if (m == 1 && m_leap(y)) return 29;
        return t[m];
    endfunction

    function automatic int m_first(int y, int m);
        int days = 0;
        for (int yy = 2000; yy < y; yy++) days += m_leap(yy) ? 366 : 365;
        for (int k = 0; k < m; k++) days += m_len(k, y);
        return (5 + days) % 7;
    endfunction

    function automatic logic [29:0] m_vec(int y, int m, int d, bit b);
        return {12'(y), 4'(m), 5'(d), 3'(m_first(y, m)), 5'(m_len(m, y)), b};
    endfunction

    function automatic logic [29:0] dut_vec();
        return {year_o, month_o, day_in_month_o, month_first_day_o, month_days_cnt_o, busy_o};
    endfunction

    task automatic model_set(int y, int m, int d);
        my = (y < 2000) ? 2000 : (y > 2999) ? 2999 : y;
        mm = (m > 11) ? 11 : m;
        md = (d == 0) ? 1 : (d > m_len(mm, my)) ? m_len(mm, my) : d;
    endtask

    task automatic model_tick();
        if (md < m_len(mm, my)) begin
            md++;
        end else begin
            md = 1;
            if (mm == 11) begin
                mm = 0;
                my = (my == 2999) ? 2000 : my + 1;
            end else begin
                mm++;
            end
        end
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_set(int y, int m, int d);
        set_en_i    = 1'b1;
        set_year_i  = 12'(y);
        set_month_i = 4'(m);
        set_day_i   = 5'(d);
        step();
        set_en_i = 1'b0;
    endtask

    // Counts cycles with busy_o high; call right after do_set.
    task automatic wait_idle(output int n, output bit to);
        n = 0;
        while (busy_o === 1'b1 && n < 3000) begin
            n++;
            step();
        end
        to = (busy_o !== 1'b0);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_i = 1'b1;
        step(); step();
        rst_i = 1'b0;
        step(); step();
        checks++;
        if (dut_vec() !== {12'd2000, 4'd0, 5'd1, 3'd5, 5'd31, 1'b0}) begin
            errors++;
            $display("FAIL reset_state: got %h want %h", dut_vec(), {12'd2000, 4'd0, 5'd1, 3'd5, 5'd31, 1'b0});
        end
    endtask

    task automatic test_set_leap();
        int n; bit to;
        do_set(2024, 1, 15);
        model_set(2024, 1, 15);
        wait_idle(n, to);
        checks++;
        if (to || n != 27) begin
            errors++;
            $display("FAIL set_busy_len: got %0d (timeout=%0d) want 27", n, to);
        end
        checks++;
        if (dut_vec() !== {12'd2024, 4'd1, 5'd15, 3'd3, 5'd29, 1'b0}) begin
            errors++;
            $display("FAIL set_2024_feb: got %h want %h", dut_vec(), {12'd2024, 4'd1, 5'd15, 3'd3, 5'd29, 1'b0});
        end
    endtask

    task automatic test_year_rollover();
        int n; bit to;
        do_set(2023, 11, 31);
        model_set(2023, 11, 31);
        wait_idle(n, to);
        checks++;
        if (to || dut_vec() !== m_vec(2023, 11, 31, 0)) begin
            errors++;
            $display("FAIL load_2023_dec: got %h want %h", dut_vec(), m_vec(2023, 11, 31, 0));
        end
        day_tick_i = 1'b1;
        step();
        day_tick_i = 1'b0;
        model_tick();
        checks++;
        if (dut_vec() !== {12'd2024, 4'd0, 5'd1, 3'd0, 5'd31, 1'b0}) begin
            errors++;
            $display("FAIL tick_new_year: got %h want %h", dut_vec(), {12'd2024, 4'd0, 5'd1, 3'd0, 5'd31, 1'b0});
        end
    endtask

    task automatic test_clamp();
        int n; bit to;
        int cy[5] = '{2100, 2000, 1990, 3500, 2001};
        int cm[5] = '{1, 1, 13, 5, 3};
        int cd[5] = '{29, 10, 0, 31, 31};
        for (int i = 0; i < 5; i++) begin
            do_set(cy[i], cm[i], cd[i]);
            model_set(cy[i], cm[i], cd[i]);
            wait_idle(n, to);
            checks++;
            if (to || dut_vec() !== m_vec(my, mm, md, 0)) begin
                errors++;
                $display("FAIL clamp_%0d: got %h want %h", i, dut_vec(), m_vec(my, mm, md, 0));
            end
        end
        do_set(2100, 1, 29);
        wait_idle(n, to);
        checks++;
        if (day_in_month_o !== 5'd28 || month_days_cnt_o !== 5'd28) begin
            errors++;
            $display("FAIL clamp_2100_feb: got day=%0d cnt=%0d want 28/28", day_in_month_o, month_days_cnt_o);
        end
        do_set(2000, 1, 10);
        model_set(2000, 1, 10);
        wait_idle(n, to);
        checks++;
        if (month_days_cnt_o !== 5'd29 || month_first_day_o !== 3'd1) begin
            errors++;
            $display("FAIL set_2000_feb: got cnt=%0d fd=%0d want 29/1", month_days_cnt_o, month_first_day_o);
        end
    endtask

    task automatic test_max_wrap();
        int n; bit to;
        do_set(2999, 11, 31);
        model_set(2999, 11, 31);
        wait_idle(n, to);
        checks++;
        if (to || n != 999 + 11 + 2) begin
            errors++;
            $display("FAIL max_busy_len: got %0d want %0d", n, 999 + 11 + 2);
        end
        day_tick_i = 1'b1;
        step();
        day_tick_i = 1'b0;
        model_tick();
        checks++;
        if (dut_vec() !== {12'd2000, 4'd0, 5'd1, 3'd5, 5'd31, 1'b0}) begin
            errors++;
            $display("FAIL max_wrap: got %h want %h", dut_vec(), {12'd2000, 4'd0, 5'd1, 3'd5, 5'd31, 1'b0});
        end
    endtask

    task automatic test_tick_during_busy();
        int n; bit to;
        logic [29:0] prev;
        prev = m_vec(my, mm, md, 1);
        do_set(2024, 1, 29);
        model_set(2024, 1, 29);
        step(); step(); step();
        checks++;
        if (dut_vec() !== prev) begin
            errors++;
            $display("FAIL hold_during_busy: got %h want %h", dut_vec(), prev);
        end
        day_tick_i = 1'b1;
        step();
        day_tick_i = 1'b1;
        step();
        day_tick_i = 1'b0;
        wait_idle(n, to);
        checks++;
        if (to || dut_vec() !== m_vec(2024, 1, 29, 0)) begin
            errors++;
            $display("FAIL commit_before_pending: got %h want %h", dut_vec(), m_vec(2024, 1, 29, 0));
        end
        step();
        model_tick();
        checks++;
        if (dut_vec() !== {12'd2024, 4'd2, 5'd1, 3'd4, 5'd31, 1'b0}) begin
            errors++;
            $display("FAIL pending_tick: got %h want %h", dut_vec(), {12'd2024, 4'd2, 5'd1, 3'd4, 5'd31, 1'b0});
        end
        step();
        checks++;
        if (dut_vec() !== m_vec(my, mm, md, 0)) begin
            errors++;
            $display("FAIL pending_once: got %h want %h", dut_vec(), m_vec(my, mm, md, 0));
        end
    endtask

    task automatic test_set_during_busy();
        int n; bit to;
        do_set(2500, 5, 5);
        step(); step();
        day_tick_i = 1'b1;
        step();
        day_tick_i = 1'b0;
        step();
        do_set(2010, 3, 7);
        model_set(2010, 3, 7);
        wait_idle(n, to);
        checks++;
        if (to || n != 10 + 3 + 2) begin
            errors++;
            $display("FAIL restart_busy_len: got %0d want %0d", n, 15);
        end
        step(); step();
        checks++;
        if (dut_vec() !== m_vec(2010, 3, 7, 0)) begin
            errors++;
            $display("FAIL restart_no_pending: got %h want %h", dut_vec(), m_vec(2010, 3, 7, 0));
        end
        day_tick_i = 1'b1;
        do_set(2012, 1, 28);
        day_tick_i = 1'b0;
        model_set(2012, 1, 28);
        wait_idle(n, to);
        step();
        checks++;
        if (to || dut_vec() !== m_vec(2012, 1, 28, 0)) begin
            errors++;
            $display("FAIL set_beats_tick: got %h want %h", dut_vec(), m_vec(2012, 1, 28, 0));
        end
    endtask

    task automatic test_random();
        int n; bit to; int y, m, d; bit t;
        for (int it = 0; it < 15; it++) begin
            y = $urandom_range(3010, 1990);
            m = $urandom_range(13, 0);
            d = ($urandom_range(3, 0) == 0) ? $urandom_range(31, 0) : $urandom_range(31, 26);
            do_set(y, m, d);
            model_set(y, m, d);
            wait_idle(n, to);
            checks++;
            if (to || n != (my - 2000) + mm + 2) begin
                errors++;
                $display("FAIL rnd_busy_len_%0d: got %0d want %0d", it, n, (my - 2000) + mm + 2);
            end
            checks++;
            if (dut_vec() !== m_vec(my, mm, md, 0)) begin
                errors++;
                $display("FAIL rnd_load_%0d: got %h want %h", it, dut_vec(), m_vec(my, mm, md, 0));
            end
            for (int c = 0; c < 30; c++) begin
                t = 1'($urandom_range(1, 0));
                day_tick_i = t;
                step();
                day_tick_i = 1'b0;
                if (t) model_tick();
                checks++;
                if (dut_vec() !== m_vec(my, mm, md, 0)) begin
                    errors++;
                    $display("FAIL rnd_tick_%0d_%0d: got %h want %h", it, c, dut_vec(), m_vec(my, mm, md, 0));
                end
            end
        end
    endtask

    task automatic test_reset_midwalk();
        do_set(2500, 5, 5);
        repeat (10) step();
        rst_i = 1'b1;
        step();
        checks++;
        if (dut_vec() !== {12'd2000, 4'd0, 5'd1, 3'd5, 5'd31, 1'b0}) begin
            errors++;
            $display("FAIL reset_midwalk: got %h want %h", dut_vec(), {12'd2000, 4'd0, 5'd1, 3'd5, 5'd31, 1'b0});
        end
        rst_i = 1'b0;
        repeat (5) step();
        checks++;
        if (dut_vec() !== {12'd2000, 4'd0, 5'd1, 3'd5, 5'd31, 1'b0}) begin
            errors++;
            $display("FAIL reset_stays_idle: got %h want %h", dut_vec(), {12'd2000, 4'd0, 5'd1, 3'd5, 5'd31, 1'b0});
        end
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_set_leap();
        test_year_rollover();
        test_clamp();
        test_max_wrap();
        test_tick_during_busy();
        test_set_during_busy();
        test_random();
        test_reset_midwalk();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
